// File: rtl/mdio_pkg.sv
// mdio_pkg: scheduler state encoding, BMSR constants and the MDIO address pack shared with mdio_core
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_WAIT_WR,
    ST_DONE
  } mdio_st_e;

  localparam logic [4:0] BMSR_REG      = 5'd1;
  localparam int         BMSR_LINK_BIT = 2;

  function automatic logic [7:0] mdio_pack(input logic [2:0] phy, input logic [4:0] ra);
    return {phy, ra};
  endfunction

endpackage

// File: rtl/mdio_rr_arb2.sv
// mdio_rr_arb2: two-way round-robin arbiter; on contention the port not granted last wins
module mdio_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last;

  always_comb gnt = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;

  // Resetting to "port 1 served last" gives port 0 the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last <= 1'b1;
    else if (en && |req) last <= gnt[1];
  end

endmodule

// File: rtl/mdio_sched.sv
// mdio_sched: serialises host requests and periodic BMSR polls onto the single mdio_core port
module mdio_sched
  import mdio_pkg::*;
#(
  parameter logic [31:0] MDC_BASE       = 32'h0000_0000,
  parameter int unsigned POLL_CYC       = 50_000_000,
  parameter logic [2:0]  POLL_PHY       = 3'd0,
  parameter int unsigned WR_GUARD_CYC   = 1536,
  parameter int unsigned RD_TIMEOUT_CYC = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_req,
  input  logic        host_rwn,
  input  logic [2:0]  host_phy,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdat,
  output logic        host_ack,
  output logic        host_err,
  output logic [15:0] host_rdat,
  output logic        mgmt_req,
  output logic [31:0] mgmt_adr,
  output logic        mgmt_rwn,
  output logic [1:0]  mgmt_wen,
  output logic [31:0] mgmt_txd,
  input  logic        mgmt_ack,
  input  logic        mgmt_rxe,
  input  logic [31:0] mgmt_rxd,
  output logic        link_up,
  output logic        link_irq
);

  localparam int unsigned WAIT_MAX = (WR_GUARD_CYC > RD_TIMEOUT_CYC) ? WR_GUARD_CYC : RD_TIMEOUT_CYC;
  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam int PW = $clog2(POLL_CYC + 1);

  mdio_st_e      state, nxt;
  logic [1:0]    gnt;
  logic          idle_gnt, rd_err, own_poll, poll_pend;
  logic [CW-1:0] wcnt;
  logic [PW-1:0] ptmr;
  logic          rxd_unused;

  assign rxd_unused = ^mgmt_rxd[31:16];

  mdio_rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({poll_pend, host_req}),
    .en   (state == ST_IDLE),
    .gnt  (gnt)
  );

  assign idle_gnt = (state == ST_IDLE) && |gnt;
  assign rd_err   = (state == ST_WAIT_RD) && !mgmt_rxe;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    nxt = idle_gnt ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   nxt = !mgmt_ack ? ST_ISSUE : (mgmt_rwn ? ST_WAIT_RD : ST_WAIT_WR);
      ST_WAIT_RD: nxt = (mgmt_rxe || wcnt == '0) ? ST_DONE : ST_WAIT_RD;
      ST_WAIT_WR: nxt = (wcnt == '0) ? ST_DONE : ST_WAIT_WR;
      default:    nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= nxt;
  end

  // mgmt_* doubles as the command register: loaded at grant, held through the transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mgmt_req  <= 1'b0;
      mgmt_adr  <= '0;
      mgmt_rwn  <= 1'b1;
      mgmt_wen  <= 2'b00;
      mgmt_txd  <= '0;
      host_ack  <= 1'b0;
      host_err  <= 1'b0;
      host_rdat <= '0;
      link_up   <= 1'b0;
      link_irq  <= 1'b0;
      own_poll  <= 1'b0;
      wcnt      <= '0;
    end else begin
      host_ack <= 1'b0;
      host_err <= 1'b0;
      link_irq <= 1'b0;
      if (idle_gnt) begin
        own_poll <= gnt[1];
        mgmt_req <= 1'b1;
        mgmt_adr <= MDC_BASE | {24'b0, gnt[1] ? mdio_pack(POLL_PHY, BMSR_REG) : mdio_pack(host_phy, host_reg)};
        mgmt_rwn <= gnt[1] | host_rwn;
        mgmt_wen <= (gnt[1] | host_rwn) ? 2'b00 : 2'b11;
        mgmt_txd <= {16'b0, gnt[1] ? 16'b0 : host_wdat};
      end
      // Read timeout is loaded two short so host_ack lands exactly RD_TIMEOUT_CYC after the ack.
      if (state == ST_ISSUE && mgmt_ack) begin
        mgmt_req <= 1'b0;
        wcnt     <= mgmt_rwn ? CW'(RD_TIMEOUT_CYC - 2) : CW'(WR_GUARD_CYC - 1);
      end else if ((state == ST_WAIT_RD || state == ST_WAIT_WR) && wcnt != '0) begin
        wcnt <= wcnt - 1'b1;
      end
      if (nxt == ST_DONE && !own_poll) begin
        host_ack <= 1'b1;
        host_err <= rd_err;
        if (mgmt_rwn && !rd_err) host_rdat <= mgmt_rxd[15:0];
      end
      if (nxt == ST_DONE && own_poll && !rd_err) begin
        link_up  <= mgmt_rxd[BMSR_LINK_BIT];
        link_irq <= mgmt_rxd[BMSR_LINK_BIT] != link_up;
      end
    end
  end

  // An expiry coinciding with the poll grant re-arms the request rather than being lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptmr      <= PW'(POLL_CYC - 1);
      poll_pend <= 1'b0;
    end else begin
      ptmr      <= (ptmr == '0) ? PW'(POLL_CYC - 1) : ptmr - 1'b1;
      poll_pend <= (ptmr == '0) | (poll_pend & ~(idle_gnt & gnt[1]));
    end
  end

endmodule

// File: tb/tb_mdio_sched.sv
// tb_mdio_sched: randomized scoreboard bench with a behavioural mdio_core and PHY register file
module tb_mdio_sched;

  localparam logic [31:0] BASE    = 32'h0004_0000;
  localparam int          P       = 5000;
  localparam int          WR      = 1536;
  localparam int          RD      = 2048;
  localparam int          RXE_LAT = 1400;
  localparam logic [2:0]  PPHY    = 3'd0;
  localparam logic [7:0]  POLL_A  = {PPHY, 5'd1};
  localparam logic [31:0] POLL_ADR = BASE | {24'b0, POLL_A};

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        host_req, host_rwn, host_ack, host_err;
  logic [2:0]  host_phy;
  logic [4:0]  host_reg;
  logic [15:0] host_wdat, host_rdat;
  logic        mgmt_req, mgmt_rwn, mgmt_ack, mgmt_rxe, link_up, link_irq;
  logic [31:0] mgmt_adr, mgmt_txd, mgmt_rxd;
  logic [1:0]  mgmt_wen;

  mdio_sched #(
    .MDC_BASE(BASE), .POLL_CYC(P), .POLL_PHY(PPHY), .WR_GUARD_CYC(WR), .RD_TIMEOUT_CYC(RD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_rwn(host_rwn), .host_phy(host_phy), .host_reg(host_reg),
    .host_wdat(host_wdat), .host_ack(host_ack), .host_err(host_err), .host_rdat(host_rdat),
    .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr), .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen),
    .mgmt_txd(mgmt_txd), .mgmt_ack(mgmt_ack), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd),
    .link_up(link_up), .link_irq(link_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rwn;
    logic [7:0]  a;
    logic [15:0] wdat;
    bit          err;
    logic [15:0] rdat;
  } exp_t;

  exp_t        sq[$];
  bit          lq[$];
  exp_t        e;
  logic [15:0] mem [256];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, edge_n = 0, ack_at = -1, rxe_at = -1;
  int          t_hack = 0, t_rxe = 0, host_acks = 0, poll_errs = 0, host_since = 0;
  bit          prev_req = 0, ref_pend = 0, last_host = 0, cur_poll = 0, sup_rxe = 0, ref_link = 0;
  logic [7:0]  cur_a = '0;
  logic [31:0] h_adr = '0, h_txd = '0;
  logic        h_rwn = 1'b1;
  logic [1:0]  h_wen = '0;
  logic [15:0] ref_rdat = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // mdio_core model: ack 2 cycles after req, rxe RXE_LAT cycles after a read ack; also tracks
  // the expected poll-pending state to judge every grant against the round-robin rule.
  initial begin
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      mgmt_ack = 1'b0; mgmt_rxe = 1'b0;
      if (!rst_n) begin
        ack_at = -1; rxe_at = -1; edge_n = 0; ref_pend = 0; last_host = 0; prev_req = 0; host_since = 0;
      end else begin
        edge_n++;
        if (mgmt_req && !prev_req) begin
          cur_poll = (mgmt_adr == POLL_ADR) && mgmt_rwn;
          if (cur_poll) begin
            chk("poll_grant_pending", 32'(ref_pend), 32'd1);
            chk("poll_starve", 32'(host_since <= 1), 32'd1);
            ref_pend = 0; last_host = 0;
          end else begin
            chk("rr_host_twice", 32'(ref_pend && last_host), 32'd0);
            if (ref_pend) host_since++;
            last_host = 1;
          end
          ack_at = cyc + 2;
        end
        prev_req = mgmt_req;
        if (cyc == ack_at) begin
          mgmt_ack = 1'b1;
          cur_a = mgmt_adr[7:0];
          if (!cur_poll) begin
            h_adr = mgmt_adr; h_rwn = mgmt_rwn; h_wen = mgmt_wen; h_txd = mgmt_txd;
            t_hack = cyc; host_acks++;
          end
          if (!mgmt_rwn) mem[cur_a] = mgmt_txd[15:0];
          else if (sup_rxe) begin
            mgmt_rxd = '0;
            if (cur_poll) poll_errs++;
          end else rxe_at = cyc + RXE_LAT;
        end
        if (cyc == rxe_at) begin
          mgmt_rxe = 1'b1;
          mgmt_rxd = {16'($urandom), mem[cur_a]};
          if (!cur_poll) t_rxe = cyc;
          else if (mem[cur_a][2] != ref_link) begin
            ref_link = mem[cur_a][2];
            lq.push_back(ref_link);
          end
        end
        if (edge_n % P == 0) begin
          if (!ref_pend) host_since = 0;
          ref_pend = 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && host_ack) begin
        if (sq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_host_ack: got 1 expected 0");
        end else begin
          e = sq.pop_front();
          if (e.rwn && !e.err) ref_rdat = e.rdat;
          chk("host_err", 32'(host_err), 32'(e.err));
          chk("host_rdat", 32'(host_rdat), 32'(ref_rdat));
          chk("mgmt_adr", h_adr, BASE | {24'b0, e.a});
          chk("mgmt_rwn", 32'(h_rwn), 32'(e.rwn));
          chk("mgmt_wen", 32'(h_wen), e.rwn ? 32'd0 : 32'd3);
          if (!e.rwn) chk("mgmt_txd", h_txd, {16'b0, e.wdat});
          chk("ack_latency", cyc, !e.rwn ? t_hack + WR + 1 : (e.err ? t_hack + RD : t_rxe + 1));
        end
      end
      if (rst_n && link_irq) begin
        if (lq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL spurious_link_irq: got 1 expected 0");
        end else chk("link_up_on_irq", 32'(link_up), 32'(lq.pop_front()));
      end
    end
  end

  task automatic wait_ack();
    for (int i = 0; i < 9000; i++) begin
      @(posedge clk); #1;
      if (host_ack) return;
    end
    chk("host_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic host_txn(input bit rwn, input logic [2:0] phy, input logic [4:0] ra,
                          input logic [15:0] wd, input bit keep);
    exp_t x;
    x.rwn = rwn; x.a = {phy, ra}; x.wdat = wd; x.err = rwn && sup_rxe; x.rdat = mem[{phy, ra}];
    sq.push_back(x);
    host_rwn = rwn; host_phy = phy; host_reg = ra; host_wdat = wd; host_req = 1'b1;
    wait_ack();
    if (!keep) host_req = 1'b0;
  endtask

  task automatic wait_link(input bit v, input int bound);
    for (int i = 0; i < bound && link_up !== v; i++) @(negedge clk);
    chk("link_wait", 32'(link_up), 32'(v));
  endtask

  task automatic chk_reset();
    chk("rst_mgmt_req", 32'(mgmt_req), 32'd0);
    chk("rst_mgmt_adr", mgmt_adr, 32'd0);
    chk("rst_mgmt_rwn", 32'(mgmt_rwn), 32'd1);
    chk("rst_mgmt_wen", 32'(mgmt_wen), 32'd0);
    chk("rst_mgmt_txd", mgmt_txd, 32'd0);
    chk("rst_host_ack", 32'(host_ack), 32'd0);
    chk("rst_host_err", 32'(host_err), 32'd0);
    chk("rst_host_rdat", 32'(host_rdat), 32'd0);
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_link_irq", 32'(link_irq), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pe, ha;
    bit rw;
    logic [2:0] phy;
    logic [4:0] ra;
    host_req = 1'b0; host_rwn = 1'b1; host_phy = '0; host_reg = '0; host_wdat = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[POLL_A] = 16'h0000;
    mem[8'h62]  = 16'h0141;
    #23;
    chk_reset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    host_txn(1'b1, 3'd3, 5'd2, 16'h0, 1'b0);
    host_txn(1'b0, 3'd0, 5'd0, 16'h8000, 1'b0);
    mem[POLL_A] = 16'h0004;
    wait_link(1'b1, 2 * P + 3000);
    mem[POLL_A] = 16'h0000;
    wait_link(1'b0, 2 * P + 3000);
    for (int i = 0; i < 12; i++) begin
      rw  = 1'($urandom);
      phy = 3'($urandom);
      ra  = 5'($urandom);
      if ({phy, ra} == POLL_A) ra = 5'd2;
      host_txn(rw, phy, ra, 16'($urandom), i < 11);
    end
    mem[POLL_A] = 16'h0004;
    wait_link(1'b1, 2 * P + 3000);
    sup_rxe = 1'b1;
    pe = poll_errs;
    host_txn(1'b1, 3'd5, 5'd7, 16'h0, 1'b0);
    for (int i = 0; i < 2 * P + 3000 && poll_errs == pe; i++) @(negedge clk);
    chk("poll_err_seen", 32'(poll_errs != pe), 32'd1);
    repeat (RD + 10) @(negedge clk);
    chk("link_hold_on_poll_err", 32'(link_up), 32'd1);
    sup_rxe = 1'b0;
    ha = host_acks;
    host_rwn = 1'b1; host_phy = 3'd2; host_reg = 5'd3; host_req = 1'b1;
    for (int i = 0; i < 6000 && host_acks == ha; i++) @(negedge clk);
    chk("rst_txn_acked", 32'(host_acks != ha), 32'd1);
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset();
    host_req = 1'b0; ref_link = 0; ref_rdat = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2500) @(negedge clk);
    chk("mgmt_req_idle", 32'(mgmt_req), 32'd0);
    chk("sb_empty", sq.size(), 32'd0);
    chk("lq_empty", lq.size(), 32'd0);
    chk("link_final", 32'(link_up), 32'(ref_link));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
